reg32_shift_ctrl: RTL and testbench
===================================

Name: reg32_shift_ctrl

Overview:
Sequencer for the 32-bit universal shift register (register_32). Accepts a job: a word, a shift count, a direction, and shift-or-rotate. It then drives the register's enb/mode/dir/s_in/d pins through load, N shift/rotate cycles and completion. Sits between a host requester (start/busy/done handshake) and one register_32 instance; all register control pins come only from this block.

Parameters:
WIDTH, 32, register data width (d bus)
CNT_W, 6, shift-count width; counts 0..WIDTH representable

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  job request; accepted only when busy=0
abort  input  1  synchronous cancel of a running job
data_in  input  WIDTH  word to parallel-load
count_in  input  CNT_W  number of shift/rotate cycles
dir_in  input  1  shift direction passed to register (0 left, 1 right)
rot_in  input  1  1 = rotate, 0 = shift
fill_in  input  1  serial fill bit driven on s_in during shift
reg_enb  output  1  register enable
reg_mode  output  2  register mode: 00 shift, 01 rotate, 10 parallel load, 11 hold
reg_dir  output  1  register direction
reg_s_in  output  1  register serial input
reg_d  output  WIDTH  register parallel input
busy  output  1  job in progress
done  output  1  one-cycle completion pulse
shift_active  output  1  high in each cycle the register shifts/rotates

Behaviour:
- All outputs registered (Moore); no combinational input->output path.
- Reset (async, any time incl. mid-job): state IDLE, reg_enb=0, reg_mode=11, reg_dir=0, reg_s_in=0, reg_d=0, busy=0, done=0, shift_active=0, counter=0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: reg_enb=0, reg_mode=11. On start=1, capture data_in, count_in, dir_in, rot_in and fill_in. Clamp the count to WIDTH if count_in>WIDTH. Go to LOAD; busy=1 from the next cycle.
- LOAD (exactly 1 cycle): reg_enb=1, reg_mode=10, reg_d=captured word. Next state is SHIFT if count!=0, else DONE.
- SHIFT: reg_enb=1, reg_mode=01 if rot else 00, reg_dir=captured dir, reg_s_in=captured fill, shift_active=1. The counter decrements each cycle. After exactly count SHIFT cycles, go to DONE.
- DONE (1 cycle): reg_enb=0, reg_mode=11, done=1, busy=1. Next state is IDLE with busy=0.
- Latency: start sampled at edge k -> LOAD at cycle k+1 -> SHIFT cycles k+2..k+1+N -> done high at k+2+N -> idle at k+3+N. Busy length is N+2 cycles.
- start while busy=1 is ignored and not queued. A start in the same cycle done=1 is ignored, because busy is still 1.
- abort=1 in LOAD or SHIFT: next cycle goes to IDLE with reg_enb=0, reg_mode=11, busy=0, no done pulse. Register contents are left as-is. abort in IDLE/DONE has no effect; in DONE, done still pulses.
- start and abort both high in IDLE: start wins (abort only acts on a running job).
- reg_d holds the captured word until the next accepted start; it is don't-care to the register outside LOAD.
- count_in=0: LOAD then DONE; busy 2 cycles; shift_active never asserted.

Decomposition:
- Shared package reg32_pkg: mode constants MODE_SHIFT=2'b00, MODE_ROT=2'b01, MODE_LOAD=2'b10, MODE_HOLD=2'b11; state encoding (2-bit: IDLE, LOAD, SHIFT, DONE).
- One natural sub-module: reg32_shift_cnt, a loadable down-counter with a zero flag. The FSM and output registers live in the top level.
- The bench instantiates reg32_shift_ctrl plus register_32 and checks q/s_out end-to-end.

Test Plan:
- Reset mid-SHIFT (assert reset during cycle 3 of a 10-shift job) -> all outputs go to reset values immediately; busy=0, no done.
- data_in=32'h8000_0001, count_in=4, dir=0, rot=1 -> busy 6 cycles; shift_active high exactly 4 cycles; done pulse; register q=32'h0000_0018.
- data_in=32'hF000_000F, count_in=8, dir=1, rot=0, fill=0 -> q=32'h00F0_0000 at done; reg_mode=00 on all 8 shift cycles.
- count_in=0, data_in=32'hDEAD_BEEF -> LOAD then done; q=32'hDEAD_BEEF; shift_active never high. count_in=40 -> clamped to 32 shifts (34 busy cycles).
- Second start pulsed during busy, and again in the done cycle -> ignored; exactly one done pulse; only the first job's word is loaded.
- abort during the 2nd SHIFT cycle of a count=5 job -> next cycle IDLE, busy=0, reg_enb=0, no done. A new start is then accepted normally.

Source files
------------

// File: rtl/reg32_pkg.sv
// Shared definitions for the register_32 shift sequencer.
//   MODE_*  : encodings driven on the register's 2-bit mode pins
//   state_t : sequencer state encoding (IDLE, LOAD, SHIFT, DONE)
package reg32_pkg;

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/reg32_shift_cnt.sv
// Loadable down-counter tracking the remaining shift/rotate cycles of a job.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val (takes priority over dec)
//   load_val   : remaining-cycle count to load
//   dec        : decrement by one (saturates at zero)
//   clr        : synchronous clear, used when a job is cancelled
//   zero       : count is zero
//   last       : count is one, i.e. the current cycle is the final shift
module reg32_shift_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);
  assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/reg32_shift_ctrl.sv
// Sequencer driving one register_32 through parallel load, N shift/rotate
// cycles and completion, with a start/busy/done host handshake.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start, abort   : job request (IDLE only) / cancel of a running job
//   data_in        : word to load; count_in : shift cycles (clamped to WIDTH)
//   dir_in, rot_in, fill_in : direction, rotate-vs-shift, serial fill bit
//   reg_enb, reg_mode, reg_dir, reg_s_in, reg_d : register control pins
//   busy, done, shift_active : job status (all outputs registered)
module reg32_shift_ctrl
  import reg32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             dir_in,
  input  logic             rot_in,
  input  logic             fill_in,
  output logic             reg_enb,
  output logic [1:0]       reg_mode,
  output logic             reg_dir,
  output logic             reg_s_in,
  output logic [WIDTH-1:0] reg_d,
  output logic             busy,
  output logic             done,
  output logic             shift_active
);

  state_t           state_reg, state_next;
  logic             dir_reg, rot_reg, fill_reg;
  logic [WIDTH-1:0] word_reg;
  logic             enb_reg, sdir_reg, s_in_reg, busy_reg, done_reg, act_reg;
  logic [1:0]       mode_reg;

  logic             accept, running, cnt_zero, cnt_last;
  logic [CNT_W-1:0] count_clamped;

  assign accept        = (state_reg == ST_IDLE) && start;
  assign running       = (state_reg == ST_LOAD) || (state_reg == ST_SHIFT);
  assign count_clamped = (count_in > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count_in;

  reg32_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (count_clamped),
    .dec      (state_reg == ST_SHIFT),
    .clr      (running && abort),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (abort)         state_next = ST_IDLE;
        else if (cnt_zero) state_next = ST_DONE;
        else               state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)         state_next = ST_IDLE;
        else if (cnt_last) state_next = ST_DONE;
      end
      default:             state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so they line up
  // with the state they describe and never depend combinationally on inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      word_reg  <= '0;
      dir_reg   <= 1'b0;
      rot_reg   <= 1'b0;
      fill_reg  <= 1'b0;
      enb_reg   <= 1'b0;
      mode_reg  <= MODE_HOLD;
      sdir_reg  <= 1'b0;
      s_in_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      act_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        word_reg <= data_in;
        dir_reg  <= dir_in;
        rot_reg  <= rot_in;
        fill_reg <= fill_in;
      end
      enb_reg  <= 1'b0;
      mode_reg <= MODE_HOLD;
      sdir_reg <= 1'b0;
      s_in_reg <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      act_reg  <= 1'b0;
      case (state_next)
        ST_LOAD: begin
          enb_reg  <= 1'b1;
          mode_reg <= MODE_LOAD;
          busy_reg <= 1'b1;
        end
        ST_SHIFT: begin
          // Captured job fields are stable here: accept can only occur in IDLE.
          enb_reg  <= 1'b1;
          mode_reg <= rot_reg ? MODE_ROT : MODE_SHIFT;
          sdir_reg <= dir_reg;
          s_in_reg <= fill_reg;
          busy_reg <= 1'b1;
          act_reg  <= 1'b1;
        end
        ST_DONE: begin
          busy_reg <= 1'b1;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign reg_enb      = enb_reg;
  assign reg_mode     = mode_reg;
  assign reg_dir      = sdir_reg;
  assign reg_s_in     = s_in_reg;
  assign reg_d        = word_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign shift_active = act_reg;

endmodule

// File: tb/tb_reg32_shift_ctrl.sv
// Bench for reg32_shift_ctrl driving a behavioural register_32 model.
// Stimulus pushes the hand-computed outcome of each job into a queue; a
// negedge monitor measures each busy window and compares it on completion.
module tb_reg32_shift_ctrl;

  logic        clk, reset, start, abort, dir_in, rot_in, fill_in;
  logic [31:0] data_in;
  logic [5:0]  count_in;
  logic        reg_enb, reg_dir, reg_s_in, busy, done, shift_active;
  logic [1:0]  reg_mode;
  logic [31:0] reg_d;

  reg32_shift_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .count_in(count_in), .dir_in(dir_in),
    .rot_in(rot_in), .fill_in(fill_in), .reg_enb(reg_enb),
    .reg_mode(reg_mode), .reg_dir(reg_dir), .reg_s_in(reg_s_in),
    .reg_d(reg_d), .busy(busy), .done(done), .shift_active(shift_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // register_32 model: 00 shift, 01 rotate, 10 load, 11 hold; dir 0 = left.
  logic [31:0] q = 32'h0;
  logic        s_out;
  assign s_out = reg_dir ? q[0] : q[31];
  always @(posedge clk) begin
    if (reg_enb) begin
      case (reg_mode)
        2'b00: q <= reg_dir ? {reg_s_in, q[31:1]} : {q[30:0], reg_s_in};
        2'b01: q <= reg_dir ? {q[0], q[31:1]} : {q[30:0], q[31]};
        2'b10: q <= reg_d;
        default: ;
      endcase
    end
  end

  typedef struct {
    string       name;
    logic [31:0] q;
    logic        sout;
    int          busy_n;
    int          shift_n;
    int          done_n;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   jobs_ended = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor
  logic in_job = 1'b0;
  int   mon_bc, mon_sc, mon_dc;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      if (!in_job) begin
        in_job = 1'b1;
        mon_bc = 0; mon_sc = 0; mon_dc = 0;
      end
      mon_bc++;
      if (shift_active === 1'b1) begin
        mon_sc++;
        if (sb_q.size() == 0) chk("shift_mode_no_job", {30'h0, reg_mode}, 32'h0000_0004);
        else                  chk({sb_q[0].name, "_mode"}, {30'h0, reg_mode}, {30'h0, sb_q[0].mode});
      end
      if (done === 1'b1) mon_dc++;
    end else if (in_job) begin
      in_job = 1'b0;
      jobs_ended++;
      if (sb_q.size() == 0) begin
        chk("unexpected_job", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("job %s: busy=%0d shifts=%0d dones=%0d q=%h s_out=%b",
                 e.name, mon_bc, mon_sc, mon_dc, q, s_out);
        chk({e.name, "_busy"},  mon_bc, e.busy_n);
        chk({e.name, "_shift"}, mon_sc, e.shift_n);
        chk({e.name, "_done"},  mon_dc, e.done_n);
        chk({e.name, "_q"},     q, e.q);
        chk({e.name, "_sout"},  {31'h0, s_out}, {31'h0, e.sout});
      end
    end
  end

  task automatic start_job(input logic [31:0] d, input logic [5:0] c,
                           input logic dr, input logic rt, input logic fl,
                           input logic ab);
    @(posedge clk); #1;
    data_in = d; count_in = c; dir_in = dr; rot_in = rt; fill_in = fl;
    start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    for (int i = 0; i < 300; i++) begin
      if (jobs_ended >= target) break;
      @(negedge clk);
    end
    if (jobs_ended < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_jobs: ended %0d, required %0d", jobs_ended, target);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_enb"},  {31'h0, reg_enb}, 32'h0);
    chk({nm, "_mode"}, {30'h0, reg_mode}, 32'h3);
    chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_done"}, {31'h0, done}, 32'h0);
    chk({nm, "_act"},  {31'h0, shift_active}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    data_in = '0; count_in = '0; dir_in = 1'b0; rot_in = 1'b0; fill_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("rst");
    chk("rst_dir",  {31'h0, reg_dir}, 32'h0);
    chk("rst_s_in", {31'h0, reg_s_in}, 32'h0);
    chk("rst_d",    reg_d, 32'h0);
    reset = 1'b0;

    // Reset during the 3rd SHIFT cycle of a 10-shift job.
    sb_q.push_back('{"rst_mid", 32'h0000_0007, 1'b0, 3, 2, 0, 2'b00});
    start_job(32'h0000_0001, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    chk("rst_mid_d", reg_d, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    wait_jobs(1);

    sb_q.push_back('{"rot4", 32'h0000_0018, 1'b0, 6, 4, 1, 2'b01});
    start_job(32'h8000_0001, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_jobs(2);

    sb_q.push_back('{"shr8", 32'h00F0_0000, 1'b0, 10, 8, 1, 2'b00});
    start_job(32'hF000_000F, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_jobs(3);

    sb_q.push_back('{"cnt0", 32'hDEAD_BEEF, 1'b1, 2, 0, 1, 2'b00});
    start_job(32'hDEAD_BEEF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_jobs(4);

    sb_q.push_back('{"clamp40", 32'hA5A5_A5A5, 1'b1, 34, 32, 1, 2'b01});
    start_job(32'hA5A5_A5A5, 6'd40, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_jobs(5);

    // Starts during SHIFT and in the DONE cycle must be ignored.
    sb_q.push_back('{"ign", 32'h0000_07F8, 1'b0, 5, 3, 1, 2'b00});
    start_job(32'h0000_00FF, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    data_in = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ign_done_cycle", {31'h0, done}, 32'h1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("ign_busy_after", {31'h0, busy}, 32'h0);
    wait_jobs(6);
    repeat (4) @(negedge clk);
    chk("ign_busy_later", {31'h0, busy}, 32'h0);
    chk("ign_reg_d", reg_d, 32'h0000_00FF);

    // Abort in the 2nd SHIFT cycle of a 5-shift job.
    sb_q.push_back('{"abort", 32'h0000_0004, 1'b0, 3, 2, 0, 2'b00});
    start_job(32'h0000_0001, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk_idle_outputs("abort_next");
    wait_jobs(7);

    // start and abort together in IDLE: start wins.
    sb_q.push_back('{"st_ab", 32'h8000_0001, 1'b1, 3, 1, 1, 2'b01});
    start_job(32'h0000_0003, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_jobs(8);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
